// File: rtl/rgbw_frame_decoder.sv
// rgbw_frame_decoder
// Decodes SPI word frames for the RGBW controller. A frame is a sync word
// followed by NUM_CH payload words and, when CHK_EN=1, an XOR checksum word.
// The payload is collected in a shadow bank and copied to ch_data in a
// single clock edge, so a partially received frame never reaches ch_data.
// A frame that stalls for TIMEOUT_CYC cycles is abandoned.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-low reset
//   rx_data      received word, stable while rx_rdy is high
//   rx_rdy       word-ready level from the SPI clock domain (asynchronous)
//   ch_data      committed channels, channel k at [k*DATA_W +: DATA_W]
//   frame_valid  one-cycle pulse when a new frame is committed
//   frame_err    one-cycle pulse on checksum mismatch or timeout
//   busy         high while a frame is being received
//   word_idx     payload words received in the current frame
module rgbw_frame_decoder #(
  parameter int unsigned       NUM_CH      = 7,
  parameter int unsigned       DATA_W      = 8,
  parameter logic [DATA_W-1:0] SYNC_WORD   = DATA_W'(8'h55),
  parameter bit                CHK_EN      = 1'b1,
  parameter int unsigned       TIMEOUT_CYC = 65535
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        rx_data,
  input  logic                     rx_rdy,
  output logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic                     frame_valid,
  output logic                     frame_err,
  output logic                     busy,
  output logic [3:0]               word_idx
);

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CHECK   = 2'd2
  } state_t;

  localparam bit              TMO_ON   = (TIMEOUT_CYC != 32'd0);
  localparam int unsigned     CNT_W    = TMO_ON ? $clog2(TIMEOUT_CYC + 32'd1) : 1;
  localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TIMEOUT_CYC);
  localparam logic [3:0]      LAST_IDX = 4'(NUM_CH - 1);

  // Running checksum step: XOR of every payload word.
  function automatic logic [DATA_W-1:0] xor_fold(input logic [DATA_W-1:0] acc,
                                                 input logic [DATA_W-1:0] w);
    return acc ^ w;
  endfunction

  state_t                   state_r;
  logic                     s1_r;
  logic                     s2_r;
  logic                     s2_d_r;
  logic                     word_evt_s;
  logic                     tmo_hit_s;
  logic [DATA_W-1:0]        shadow_r [NUM_CH];
  logic [DATA_W-1:0]        chk_r;
  logic [CNT_W-1:0]         tmo_cnt_r;
  logic [3:0]               word_idx_r;
  logic [NUM_CH*DATA_W-1:0] ch_data_r;
  logic [NUM_CH*DATA_W-1:0] commit_s;
  logic                     frame_valid_r;
  logic                     frame_err_r;
  logic                     busy_r;

  // One event per rising edge of the synchronised strobe.
  assign word_evt_s = s2_r & ~s2_d_r;
  // Expiry is only honoured when no word arrives in the same cycle.
  assign tmo_hit_s  = TMO_ON && busy_r && (tmo_cnt_r == TMO_VAL);

  // Image loaded into ch_data on commit; without a checksum the last
  // payload word is still on rx_data at the committing edge.
  always_comb begin
    commit_s = '0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      if (!CHK_EN && (k == int'(NUM_CH) - 1)) begin
        commit_s[k*DATA_W +: DATA_W] = rx_data;
      end else begin
        commit_s[k*DATA_W +: DATA_W] = shadow_r[k];
      end
    end
  end

  // Two-flop synchroniser and edge register for rx_rdy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_r   <= 1'b0;
      s2_r   <= 1'b0;
      s2_d_r <= 1'b0;
    end else begin
      s1_r   <= rx_rdy;
      s2_r   <= s1_r;
      s2_d_r <= s2_r;
    end
  end

  // Frame FSM with shadow bank, checksum, timeout counter and outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r       <= ST_HUNT;
      chk_r         <= '0;
      tmo_cnt_r     <= '0;
      word_idx_r    <= 4'd0;
      ch_data_r     <= '0;
      frame_valid_r <= 1'b0;
      frame_err_r   <= 1'b0;
      busy_r        <= 1'b0;
      for (int k = 0; k < int'(NUM_CH); k++) begin
        shadow_r[k] <= '0;
      end
    end else begin
      frame_valid_r <= 1'b0;
      frame_err_r   <= 1'b0;

      // Held at zero outside a frame; saturates so it can never wrap.
      if (!busy_r || word_evt_s) begin
        tmo_cnt_r <= '0;
      end else if (TMO_ON && (tmo_cnt_r != TMO_VAL)) begin
        tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
      end else begin
        tmo_cnt_r <= tmo_cnt_r;
      end

      case (state_r)
        ST_HUNT: begin
          if (word_evt_s && (rx_data == SYNC_WORD)) begin
            state_r    <= ST_PAYLOAD;
            busy_r     <= 1'b1;
            word_idx_r <= 4'd0;
            chk_r      <= '0;
          end
        end

        ST_PAYLOAD: begin
          if (word_evt_s) begin
            for (int k = 0; k < int'(NUM_CH); k++) begin
              if (word_idx_r == 4'(k)) begin
                shadow_r[k] <= rx_data;
              end
            end
            chk_r <= xor_fold(chk_r, rx_data);
            if (word_idx_r == LAST_IDX) begin
              if (CHK_EN) begin
                state_r    <= ST_CHECK;
                word_idx_r <= word_idx_r + 4'd1;
              end else begin
                ch_data_r     <= commit_s;
                frame_valid_r <= 1'b1;
                state_r       <= ST_HUNT;
                busy_r        <= 1'b0;
                word_idx_r    <= 4'd0;
              end
            end else begin
              word_idx_r <= word_idx_r + 4'd1;
            end
          end else if (tmo_hit_s) begin
            frame_err_r <= 1'b1;
            state_r     <= ST_HUNT;
            busy_r      <= 1'b0;
            word_idx_r  <= 4'd0;
            for (int k = 0; k < int'(NUM_CH); k++) begin
              shadow_r[k] <= '0;
            end
          end
        end

        ST_CHECK: begin
          if (word_evt_s) begin
            if (rx_data == chk_r) begin
              ch_data_r     <= commit_s;
              frame_valid_r <= 1'b1;
            end else begin
              frame_err_r <= 1'b1;
            end
            state_r    <= ST_HUNT;
            busy_r     <= 1'b0;
            word_idx_r <= 4'd0;
          end else if (tmo_hit_s) begin
            frame_err_r <= 1'b1;
            state_r     <= ST_HUNT;
            busy_r      <= 1'b0;
            word_idx_r  <= 4'd0;
            for (int k = 0; k < int'(NUM_CH); k++) begin
              shadow_r[k] <= '0;
            end
          end
        end

        default: begin
          state_r    <= ST_HUNT;
          busy_r     <= 1'b0;
          word_idx_r <= 4'd0;
        end
      endcase
    end
  end

  assign ch_data     = ch_data_r;
  assign frame_valid = frame_valid_r;
  assign frame_err   = frame_err_r;
  assign busy        = busy_r;
  assign word_idx    = word_idx_r;

endmodule

// File: tb/tb_rgbw_frame_decoder.sv
// Testbench for rgbw_frame_decoder: a checksummed 7-channel instance with a
// 100-cycle timeout, and a 1-channel instance without checksum or timeout.
module tb_rgbw_frame_decoder;

  localparam int NCH = 7;
  localparam int TMO = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic [7:0]     rx_data;
  logic           rx_rdy;
  logic [NCH*8-1:0] ch_data;
  logic           frame_valid, frame_err, busy;
  logic [3:0]     word_idx;

  logic [7:0]     l_rx_data;
  logic           l_rx_rdy;
  logic [7:0]     l_ch_data;
  logic           l_valid, l_err, l_busy;
  logic [3:0]     l_idx;

  rgbw_frame_decoder #(.NUM_CH(NCH), .DATA_W(8), .SYNC_WORD(8'h55),
                       .CHK_EN(1'b1), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_rdy(rx_rdy),
    .ch_data(ch_data), .frame_valid(frame_valid), .frame_err(frame_err),
    .busy(busy), .word_idx(word_idx));

  rgbw_frame_decoder #(.NUM_CH(1), .DATA_W(8), .SYNC_WORD(8'h55),
                       .CHK_EN(1'b0), .TIMEOUT_CYC(0)) dut_l (
    .clk(clk), .reset(reset), .rx_data(l_rx_data), .rx_rdy(l_rx_rdy),
    .ch_data(l_ch_data), .frame_valid(l_valid), .frame_err(l_err),
    .busy(l_busy), .word_idx(l_idx));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counters and exclusivity monitor for the main instance.
  int act_valids = 0;
  int act_errs   = 0;
  bit both_seen  = 1'b0;
  always @(negedge clk) begin
    if (frame_valid === 1'b1) act_valids <= act_valids + 1;
    if (frame_err === 1'b1)   act_errs   <= act_errs + 1;
    if (frame_valid === 1'b1 && frame_err === 1'b1) both_seen <= 1'b1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xor_of(input logic [7:0] q[$]);
    logic [7:0] x = 8'h00;
    foreach (q[i]) x ^= q[i];
    return x;
  endfunction

  // Reference model: a frame is sync, NUM_CH payload words, then a checksum.
  // Timeout: the frame dies if the next word lands TMO+2 or more edges after
  // the previous one (expiry fires at TMO+1 unless a word lands there).
  bit          m_in = 1'b0;
  logic [7:0]  m_q[$];
  logic [NCH*8-1:0] m_ch = '0;
  int          m_last = 0;
  int          m_valids = 0;
  int          m_errs = 0;

  task automatic model_word(input logic [7:0] d, input int edge_no,
                            output logic ev, output logic ee,
                            output logic [3:0] eidx, output logic eb);
    if (m_in && (edge_no - m_last) >= TMO + 2) begin
      m_in = 1'b0;
      m_errs++;
    end
    m_last = edge_no;
    ev = 1'b0;
    ee = 1'b0;
    if (!m_in) begin
      if (d == 8'h55) begin
        m_in = 1'b1;
        m_q.delete();
      end
    end else if (m_q.size() < NCH) begin
      m_q.push_back(d);
    end else begin
      if (d == xor_of(m_q)) begin
        ev = 1'b1;
        m_valids++;
        for (int k = 0; k < NCH; k++) m_ch[k*8 +: 8] = m_q[k];
      end else begin
        ee = 1'b1;
        m_errs++;
      end
      m_in = 1'b0;
    end
    eidx = m_in ? 4'(m_q.size()) : 4'd0;
    eb   = m_in;
  endtask

  logic       av, ae, ab;
  logic [3:0] ai;

  // Called just after a negedge: raise the strobe, check at the negedge after
  // the consuming edge (3rd posedge), hold, drop, and let the synchroniser settle.
  task automatic send_word(input logic [7:0] d, input int hold);
    logic ev, ee, eb;
    logic [3:0] ei;
    rx_data = d;
    rx_rdy  = 1'b1;
    model_word(d, cyc + 3, ev, ee, ei, eb);
    repeat (3) @(posedge clk);
    @(negedge clk);
    av = frame_valid; ae = frame_err; ai = word_idx; ab = busy;
    chk("m_valid", frame_valid, ev);
    chk("m_err", frame_err, ee);
    chk("m_idx", word_idx, ei);
    chk("m_busy", busy, eb);
    chk("m_ch_data", ch_data, m_ch);
    repeat (hold) @(negedge clk);
    rx_rdy = 1'b0;
    @(negedge clk);
    chk("pulse_one_cycle", {frame_valid, frame_err}, 2'b00);
    chk("idx_no_second_evt", word_idx, ei);
    repeat (2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] p[$], input logic bad);
    send_word(8'h55, 0);
    foreach (p[i]) send_word(p[i], 0);
    send_word(bad ? (xor_of(p) ^ 8'($urandom_range(1, 255))) : xor_of(p), 0);
  endtask

  task automatic l_send(input logic [7:0] d);
    l_rx_data = d;
    l_rx_rdy  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic l_drop();
    l_rx_rdy = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       v;
    logic       e;
    logic [3:0] idx;
    logic       b;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input logic [7:0] d, input logic v, input logic e,
                              input logic [3:0] idx, input logic b);
    vec_t r;
    r.d = d; r.v = v; r.e = e; r.idx = idx; r.b = b;
    return r;
  endfunction

  localparam logic [NCH*8-1:0] C1 = 56'h04_D3_C2_B1_A0_02_10;
  localparam logic [NCH*8-1:0] C3 = 56'h06_05_04_03_02_01_55;

  initial begin
    logic [7:0] p[$];
    logic [7:0] pay1[$];
    int kind, n;

    reset = 1'b0; rx_rdy = 1'b0; rx_data = 8'h00;
    l_rx_rdy = 1'b0; l_rx_data = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ch_data", ch_data, '0);
    chk("rst_flags", {frame_valid, frame_err, busy}, 3'b000);
    chk("rst_idx", word_idx, 4'd0);
    chk("rst_l_ch_data", l_ch_data, 8'h00);
    reset = 1'b1;
    @(negedge clk);

    // Good frame (XOR of payload is 0x16), same frame with bad checksum 0x0E,
    // garbage in HUNT, then a frame with 0x55 as payload data.
    pay1 = '{8'h10, 8'h02, 8'hA0, 8'hB1, 8'hC2, 8'hD3, 8'h04};
    for (int r = 0; r < 2; r++) begin
      tbl.push_back(mk(8'h55, 1'b0, 1'b0, 4'd0, 1'b1));
      for (int i = 0; i < NCH; i++) tbl.push_back(mk(pay1[i], 1'b0, 1'b0, 4'(i + 1), 1'b1));
      tbl.push_back(mk((r == 0) ? 8'h16 : 8'h0E, (r == 0), (r == 1), 4'd0, 1'b0));
    end
    tbl.push_back(mk(8'h00, 1'b0, 1'b0, 4'd0, 1'b0));
    tbl.push_back(mk(8'hFF, 1'b0, 1'b0, 4'd0, 1'b0));
    tbl.push_back(mk(8'hAA, 1'b0, 1'b0, 4'd0, 1'b0));
    tbl.push_back(mk(8'h55, 1'b0, 1'b0, 4'd0, 1'b1));
    tbl.push_back(mk(8'h55, 1'b0, 1'b0, 4'd1, 1'b1));
    for (int i = 1; i < NCH; i++) tbl.push_back(mk(8'(i), 1'b0, 1'b0, 4'(i + 1), 1'b1));
    tbl.push_back(mk(8'h52, 1'b1, 1'b0, 4'd0, 1'b0));

    for (int i = 0; i < tbl.size(); i++) begin
      send_word(tbl[i].d, 0);
      chk("tbl_valid", av, tbl[i].v);
      chk("tbl_err", ae, tbl[i].e);
      chk("tbl_idx", ai, tbl[i].idx);
      chk("tbl_busy", ab, tbl[i].b);
      if (i == 8 || i == 17) chk("tbl_ch_data_c1", ch_data, C1);
    end
    chk("tbl_ch_data_c3", ch_data, C3);

    // Strobe latency: not consumed at the 2nd edge, consumed at the 3rd;
    // a level held for 50 cycles yields one word only.
    rx_data = 8'h55;
    rx_rdy  = 1'b1;
    model_word(8'h55, cyc + 3, av, ae, ai, ab);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("strobe_early_busy", busy, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("strobe_edge3_busy", busy, 1'b1);
    repeat (50) @(negedge clk);
    chk("strobe_held_idx", word_idx, 4'd0);
    rx_rdy = 1'b0;
    repeat (3) @(negedge clk);
    foreach (pay1[i]) send_word(pay1[i], 0);
    send_word(8'h16, 0);
    chk("strobe_frame_commit", ch_data, C1);

    // Timeout: last word at edge E, expiry pulse follows edge E+101.
    send_word(8'h55, 0); send_word(8'h11, 0); send_word(8'h22, 0);
    repeat (97) @(negedge clk);
    chk("tmo_before_err", frame_err, 1'b0);
    chk("tmo_before_busy", busy, 1'b1);
    @(negedge clk);
    chk("tmo_err", frame_err, 1'b1);
    chk("tmo_idx", word_idx, 4'd0);
    chk("tmo_busy", busy, 1'b0);
    m_in = 1'b0;
    m_errs++;
    @(negedge clk);
    chk("tmo_err_once", frame_err, 1'b0);
    p = '{8'h21, 8'h43, 8'h65, 8'h87, 8'hA9, 8'hCB, 8'hED};
    send_frame(p, 1'b0);
    chk("tmo_next_commit", ch_data, 56'hED_CB_A9_87_65_43_21);

    // A word consumed exactly on the expiry cycle keeps the frame alive.
    send_word(8'h55, 0); send_word(8'h11, 0); send_word(8'h22, 0);
    repeat (95) @(negedge clk);
    send_word(8'h33, 0);
    chk("keepalive_idx", ai, 4'd3);
    chk("keepalive_err", ae, 1'b0);
    p = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    for (int i = 3; i < NCH; i++) send_word(p[i], 0);
    send_word(xor_of(p), 0);
    chk("keepalive_commit", ch_data, 56'h77_66_55_44_33_22_11);

    // Reset mid-frame after three payload words.
    send_word(8'h55, 0); send_word(8'hA1, 0); send_word(8'hA2, 0); send_word(8'hA3, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_ch_data", ch_data, '0);
    chk("midrst_idx", word_idx, 4'd0);
    chk("midrst_flags", {frame_valid, frame_err, busy}, 3'b000);
    reset = 1'b1;
    m_in = 1'b0;
    m_ch = '0;
    @(negedge clk);

    // Single channel, no checksum, timeout disabled.
    l_send(8'h55);
    chk("leg_sync_busy", l_busy, 1'b1);
    l_drop();
    repeat (300) @(negedge clk);
    chk("leg_no_timeout", {l_busy, l_err}, 2'b10);
    l_send(8'h3C);
    chk("leg_valid", l_valid, 1'b1);
    chk("leg_ch_data", l_ch_data, 8'h3C);
    chk("leg_idle", {l_busy, l_idx}, 5'd0);
    l_drop();
    chk("leg_valid_drop", l_valid, 1'b0);

    // Randomised traffic against the model.
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 3);
      p.delete();
      n = (kind == 3) ? $urandom_range(0, NCH - 1) : NCH;
      for (int i = 0; i < n; i++) p.push_back(8'($urandom_range(0, 255)));
      if (kind == 0) begin
        send_word(8'($urandom_range(0, 255)), 0);
      end else if (kind == 3) begin
        send_word(8'h55, 0);
        foreach (p[i]) send_word(p[i], 0);
      end else begin
        send_frame(p, kind == 2);
      end
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(90, 110)) @(negedge clk);
    end

    // Let any pending timeout expire, then reconcile pulse counts.
    repeat (250) @(negedge clk);
    if (m_in && (cyc - m_last) >= TMO + 1) begin
      m_in = 1'b0;
      m_errs++;
    end
    chk("valid_pulse_count", act_valids, m_valids);
    chk("err_pulse_count", act_errs, m_errs);
    chk("valid_err_exclusive", both_seen, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
